// File: rtl/ntt_host_loader.sv
// ntt_host_loader: host-side driver for the Kyber NTT/INTT core.
// Streams N coefficients into the core input RAM as even/odd pairs, waits for
// the core to finish, then returns the N/2 result pairs as a stream.
//
// Handshakes: on s_*, a beat transfers on any clock edge where s_valid and
// s_ready are both high; s_ready never depends on s_valid in the same cycle.
// On m_*, m_valid marks a pair for exactly one cycle and there is no
// backpressure, so the consumer must take every pair as it appears.
module ntt_host_loader #(
  parameter int N       = 256,
  parameter int DW      = 16,
  parameter int AW      = 8,
  parameter int Q       = 3329,
  parameter int TIMEOUT = 4096
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_go,
  input  logic          cmd_mode,
  input  logic          s_valid,
  input  logic [DW-1:0] s_data,
  output logic          s_ready,
  output logic          core_start,
  output logic          core_mode,
  output logic          core_we,
  output logic [AW-1:0] core_addr_a,
  output logic [AW-1:0] core_addr_b,
  output logic [DW-1:0] core_data_a,
  output logic [DW-1:0] core_data_b,
  input  logic          core_cal_done,
  input  logic [DW-1:0] core_data_out1,
  input  logic [DW-1:0] core_data_out2,
  output logic          m_valid,
  output logic [DW-1:0] m_data_a,
  output logic [DW-1:0] m_data_b,
  output logic [AW-2:0] m_index,
  output logic          busy,
  output logic          done,
  output logic          err_range,
  output logic          err_timeout
);

  localparam int PW = AW - 1;
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_WAIT_CORE = 3'd2,
    S_DRAIN     = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;         // accepted beat index
  logic [PW-1:0] pcnt_q, pcnt_d;       // drained pair index
  logic [TW-1:0] tcnt_q, tcnt_d;       // cycles spent waiting for the core
  logic [DW-1:0] hold_q, hold_d;       // even coefficient awaiting its partner
  logic          cal_prev_q, cal_prev_d;
  logic          s_ready_q, s_ready_d;
  logic          core_start_q, core_start_d;
  logic          core_mode_q, core_mode_d;
  logic          core_we_q, core_we_d;
  logic [AW-1:0] core_addr_a_q, core_addr_a_d;
  logic [AW-1:0] core_addr_b_q, core_addr_b_d;
  logic [DW-1:0] core_data_a_q, core_data_a_d;
  logic [DW-1:0] core_data_b_q, core_data_b_d;
  logic          m_valid_q, m_valid_d;
  logic [DW-1:0] m_data_a_q, m_data_a_d;
  logic [DW-1:0] m_data_b_q, m_data_b_d;
  logic [PW-1:0] m_index_q, m_index_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_range_q, err_range_d;
  logic          err_timeout_q, err_timeout_d;
  logic          cal_rise;

  assign cal_rise = core_cal_done & ~cal_prev_q;

  // Next-state and registered-output computation; pulses default low, the rest hold.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pcnt_d        = pcnt_q;
    tcnt_d        = tcnt_q;
    hold_d        = hold_q;
    cal_prev_d    = core_cal_done;
    s_ready_d     = s_ready_q;
    core_start_d  = core_start_q;
    core_mode_d   = core_mode_q;
    core_we_d     = 1'b0;
    core_addr_a_d = core_addr_a_q;
    core_addr_b_d = core_addr_b_q;
    core_data_a_d = core_data_a_q;
    core_data_b_d = core_data_b_q;
    m_valid_d     = 1'b0;
    m_data_a_d    = m_data_a_q;
    m_data_b_d    = m_data_b_q;
    m_index_d     = m_index_q;
    done_d        = 1'b0;
    err_range_d   = err_range_q;
    err_timeout_d = err_timeout_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_go) begin
          state_d       = S_LOAD;
          core_mode_d   = cmd_mode;
          err_range_d   = 1'b0;
          err_timeout_d = 1'b0;
          cnt_d         = '0;
          pcnt_d        = '0;
          tcnt_d        = '0;
          core_start_d  = 1'b1;
          s_ready_d     = 1'b1;
        end
      end
      S_LOAD: begin
        if (s_ready_q) begin
          if (s_valid) begin
            if (s_data >= DW'(Q)) err_range_d = 1'b1;
            if (cnt_q[0] == 1'b0) begin
              hold_d = s_data;
            end else begin
              core_we_d     = 1'b1;
              core_addr_a_d = {cnt_q[AW-1:1], 1'b0};
              core_addr_b_d = cnt_q;
              core_data_a_d = hold_q;
              core_data_b_d = s_data;
            end
            if (cnt_q == AW'(N - 1)) s_ready_d = 1'b0;
            cnt_d = cnt_q + AW'(1);
          end
        end else begin
          // One tail cycle after the last beat lets the final write land
          // while core_start is still high.
          state_d      = S_WAIT_CORE;
          core_start_d = 1'b0;
          tcnt_d       = '0;
        end
      end
      S_WAIT_CORE: begin
        if (cal_rise) begin
          m_valid_d  = 1'b1;
          m_data_a_d = core_data_out1;
          m_data_b_d = core_data_out2;
          m_index_d  = '0;
          pcnt_d     = PW'(1);
          state_d    = S_DRAIN;
        end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
          err_timeout_d = 1'b1;
          done_d        = 1'b1;
          state_d       = S_IDLE;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      S_DRAIN: begin
        m_valid_d  = 1'b1;
        m_data_a_d = core_data_out1;
        m_data_b_d = core_data_out2;
        m_index_d  = pcnt_q;
        pcnt_d     = pcnt_q + PW'(1);
        if (pcnt_q == PW'(N / 2 - 1)) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset clears everything asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      pcnt_q        <= '0;
      tcnt_q        <= '0;
      hold_q        <= '0;
      cal_prev_q    <= 1'b0;
      s_ready_q     <= 1'b0;
      core_start_q  <= 1'b0;
      core_mode_q   <= 1'b0;
      core_we_q     <= 1'b0;
      core_addr_a_q <= '0;
      core_addr_b_q <= '0;
      core_data_a_q <= '0;
      core_data_b_q <= '0;
      m_valid_q     <= 1'b0;
      m_data_a_q    <= '0;
      m_data_b_q    <= '0;
      m_index_q     <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_range_q   <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      pcnt_q        <= pcnt_d;
      tcnt_q        <= tcnt_d;
      hold_q        <= hold_d;
      cal_prev_q    <= cal_prev_d;
      s_ready_q     <= s_ready_d;
      core_start_q  <= core_start_d;
      core_mode_q   <= core_mode_d;
      core_we_q     <= core_we_d;
      core_addr_a_q <= core_addr_a_d;
      core_addr_b_q <= core_addr_b_d;
      core_data_a_q <= core_data_a_d;
      core_data_b_q <= core_data_b_d;
      m_valid_q     <= m_valid_d;
      m_data_a_q    <= m_data_a_d;
      m_data_b_q    <= m_data_b_d;
      m_index_q     <= m_index_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_range_q   <= err_range_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign s_ready     = s_ready_q;
  assign core_start  = core_start_q;
  assign core_mode   = core_mode_q;
  assign core_we     = core_we_q;
  assign core_addr_a = core_addr_a_q;
  assign core_addr_b = core_addr_b_q;
  assign core_data_a = core_data_a_q;
  assign core_data_b = core_data_b_q;
  assign m_valid     = m_valid_q;
  assign m_data_a    = m_data_a_q;
  assign m_data_b    = m_data_b_q;
  assign m_index     = m_index_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err_range   = err_range_q;
  assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_ntt_host_loader.sv
// tb_ntt_host_loader: randomized bench for ntt_host_loader with a stub core.
// Expected core writes and result pairs are built per job from the coefficient
// array and the stub core's output schedule, then consumed by a per-cycle monitor.
module tb_ntt_host_loader;
  localparam int N  = 256;
  localparam int DW = 16;
  localparam int AW = 8;
  localparam int Q  = 3329;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_go = 1'b0, cmd_mode = 1'b0;
  logic          s_valid = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_ready, core_start, core_mode, core_we;
  logic [AW-1:0] core_addr_a, core_addr_b;
  logic [DW-1:0] core_data_a, core_data_b;
  logic          core_cal_done = 1'b0;
  logic [DW-1:0] core_data_out1 = '0, core_data_out2 = '0;
  logic          m_valid;
  logic [DW-1:0] m_data_a, m_data_b;
  logic [AW-2:0] m_index;
  logic          busy, done, err_range, err_timeout;

  ntt_host_loader #(.N(N), .DW(DW), .AW(AW), .Q(Q), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .cmd_go(cmd_go), .cmd_mode(cmd_mode),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .core_start(core_start), .core_mode(core_mode), .core_we(core_we),
    .core_addr_a(core_addr_a), .core_addr_b(core_addr_b),
    .core_data_a(core_data_a), .core_data_b(core_data_b),
    .core_cal_done(core_cal_done), .core_data_out1(core_data_out1),
    .core_data_out2(core_data_out2), .m_valid(m_valid), .m_data_a(m_data_a),
    .m_data_b(m_data_b), .m_index(m_index), .busy(busy), .done(done),
    .err_range(err_range), .err_timeout(err_timeout)
  );

  // Clock
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Scoreboard state: {addr_a, addr_b, data_a, data_b} and {index, a, b}
  logic [2*AW+2*DW-1:0] exp_wr_q[$];
  logic [AW-1+2*DW-1:0] exp_m_q[$];
  logic exp_mode = 1'b0;
  logic exp_err = 1'b0;
  int acc_cnt, acc_last_cyc, rise_cyc;
  int m_cnt, done_cnt, done_cyc, fall_cyc, first_m_cyc, last_wr_cyc;
  bit fall_seen;
  int last_wr_b, last_wr_db, wr7_db, last_m_idx, last_m_a, last_m_b;
  logic prev_we = 1'b0, prev_start = 1'b0, prev_done = 1'b0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Per-cycle compare process, sampling 1 time unit after each rising edge
  always @(posedge clk) begin
    logic [2*AW+2*DW-1:0] e;
    logic [AW-1+2*DW-1:0] em;
    cyc++;
    #1;
    if (rst) begin
      prev_we = 1'b0; prev_start = 1'b0; prev_done = 1'b0;
    end else begin
      if (core_we) begin
        chk("we_back_to_back", int'(prev_we), 0);
        chk("we_with_start", int'(core_start), 1);
        if (exp_wr_q.size() == 0) begin
          chk("we_unexpected", 1, 0);
        end else begin
          e = exp_wr_q.pop_front();
          chk("wr_addr_a", int'(core_addr_a), int'(e[2*AW+2*DW-1 -: AW]));
          chk("wr_addr_b", int'(core_addr_b), int'(e[AW+2*DW-1 -: AW]));
          chk("wr_data_a", int'(core_data_a), int'(e[2*DW-1 -: DW]));
          chk("wr_data_b", int'(core_data_b), int'(e[DW-1:0]));
          chk("wr_pair_complete", int'(acc_cnt >= int'(core_addr_b) + 1), 1);
        end
        last_wr_cyc = cyc;
        last_wr_b   = int'(core_addr_b);
        last_wr_db  = int'(core_data_b);
        if (core_addr_b == AW'(7)) wr7_db = int'(core_data_b);
      end
      prev_we = core_we;
      if (busy) chk("core_mode", int'(core_mode), int'(exp_mode));
      else chk("idle_outputs", int'({s_ready, core_we, core_start}), 0);
      chk("err_range_live", int'(err_range), int'(exp_err));
      if (prev_start && !core_start) begin
        fall_cyc = cyc;
        fall_seen = 1'b1;
      end
      prev_start = core_start;
      if (m_valid) begin
        if (m_cnt == 0) first_m_cyc = cyc;
        m_cnt++;
        if (exp_m_q.size() == 0) begin
          chk("m_unexpected", 1, 0);
        end else begin
          em = exp_m_q.pop_front();
          chk("m_index", int'(m_index), int'(em[AW-2+2*DW -: AW-1]));
          chk("m_data_a", int'(m_data_a), int'(em[2*DW-1 -: DW]));
          chk("m_data_b", int'(m_data_b), int'(em[DW-1:0]));
        end
        last_m_idx = int'(m_index);
        last_m_a   = int'(m_data_a);
        last_m_b   = int'(m_data_b);
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        chk("done_width", int'(prev_done), 0);
      end
      prev_done = done;
    end
  end

  // One complete job: load, stub-core wait/drain, completion checks.
  task automatic run_job(input bit mode, input int kind, input int stall,
                         input int inj_idx, input int inj_val, input bit to_mode,
                         input bit pre_high, input bit early_fall, input bit ign,
                         input int abort_at, input int b1, input int b2);
    logic [DW-1:0] c[N];
    bit any_hi;
    int i, g;
    any_hi = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (kind == 0) c[k] = DW'(k);
      else if (kind == 1) c[k] = DW'($urandom_range(0, Q - 1));
      else c[k] = DW'($urandom_range(0, 65535));
    end
    if (inj_idx >= 0) c[inj_idx] = DW'(inj_val);
    for (int k = 0; k < N; k++) if (int'(c[k]) >= Q) any_hi = 1'b1;
    exp_wr_q.delete();
    exp_m_q.delete();
    for (int k = 0; k < N / 2; k++)
      exp_wr_q.push_back({AW'(2 * k), AW'(2 * k + 1), c[2 * k], c[2 * k + 1]});
    if (!to_mode)
      for (int k = 0; k < N / 2; k++)
        exp_m_q.push_back({(AW - 1)'(k), DW'(b1 + k), DW'(b2 + k)});
    m_cnt = 0; done_cnt = 0; fall_seen = 1'b0; acc_cnt = 0;
    // Input offered while idle must be ignored
    repeat (2) begin
      @(negedge clk);
      s_valid = 1'b1;
      s_data = DW'($urandom);
    end
    @(negedge clk);
    s_valid = 1'b0;
    cmd_go = 1'b1;
    cmd_mode = mode;
    exp_mode = mode;
    exp_err = 1'b0;
    core_cal_done = pre_high;
    core_data_out1 = 16'hdead;
    core_data_out2 = 16'hdead;
    i = 0;
    g = 0;
    while (i < N && g < 20000) begin
      @(negedge clk);
      g++;
      cmd_go = (ign && i == 50);
      cmd_mode = (ign && i == 50) ? ~mode : mode;
      s_valid = ($urandom_range(0, 99) >= stall);
      s_data = s_valid ? c[i] : DW'($urandom);
      if (s_valid && s_ready) begin
        acc_cnt++;
        if (int'(c[i]) >= Q) exp_err = 1'b1;
        acc_last_cyc = cyc;
        i++;
        if (i == abort_at) begin
          @(negedge clk);
          s_valid = 1'b0;
          chk("we_before_reset", int'(core_we), 1);
          rst = 1'b1;
          #1;
          chk("rst_core_start", int'(core_start), 0);
          chk("rst_core_we", int'(core_we), 0);
          chk("rst_busy", int'(busy), 0);
          chk("rst_s_ready", int'(s_ready), 0);
          exp_err = 1'b0;
          exp_wr_q.delete();
          exp_m_q.delete();
          repeat (3) @(negedge clk);
          rst = 1'b0;
          return;
        end
      end
    end
    chk("load_bound", i, N);
    @(negedge clk);
    s_valid = 1'b0;
    cmd_go = 1'b0;
    g = 0;
    while (!fall_seen && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (!fall_seen) chk("wait_entry_bound", 0, 1);
    if (pre_high) begin
      repeat (5) @(negedge clk);
      core_cal_done = 1'b0;
      repeat (3) @(negedge clk);
    end
    if (!to_mode) begin
      repeat (20) @(negedge clk);
      for (int j = 0; j < N / 2 + 4; j++) begin
        @(negedge clk);
        if (j == 0) rise_cyc = cyc;
        core_cal_done = !(early_fall && j >= 10);
        core_data_out1 = (j < N / 2) ? DW'(b1 + j) : 16'hbeef;
        core_data_out2 = (j < N / 2) ? DW'(b2 + j) : 16'hbeef;
      end
      core_cal_done = 1'b0;
    end
    g = 0;
    while (busy && g < 300) begin
      @(negedge clk);
      g++;
    end
    if (busy) chk("job_end_bound", 0, 1);
    @(negedge clk);
    chk("busy_end", int'(busy), 0);
    chk("wr_left", exp_wr_q.size(), 0);
    chk("m_left", exp_m_q.size(), 0);
    chk("m_count", m_cnt, to_mode ? 0 : N / 2);
    chk("done_count", done_cnt, 1);
    chk("err_timeout", int'(err_timeout), int'(to_mode));
    chk("err_range_end", int'(err_range), int'(any_hi));
    chk("last_wr_latency", last_wr_cyc - acc_last_cyc, 1);
    chk("start_fall_latency", fall_cyc - acc_last_cyc, 2);
    if (to_mode) chk("timeout_latency", done_cyc - fall_cyc, TO);
    else chk("m_first_latency", first_m_cyc - rise_cyc, 1);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_outputs", int'({s_ready, core_start, core_mode, core_we, m_valid,
                               busy, done, err_range, err_timeout}), 0);
    chk("reset_addr", int'({core_addr_a, core_addr_b}), 0);
    chk("reset_m", int'({m_data_a, m_data_b, m_index}), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Basic load 0..255, no gaps, then drain of 1000+i / 2000+i
    run_job(1'b0, 0, 0, -1, 0, 1'b0, 1'b0, 1'b0, 1'b0, -1, 1000, 2000);
    chk("lit_last_wr_addr_b", last_wr_b, 255);
    chk("lit_last_wr_data_b", last_wr_db, 255);
    chk("lit_last_m_index", last_m_idx, 127);
    chk("lit_last_m_a", last_m_a, 1127);
    chk("lit_last_m_b", last_m_b, 2127);

    // Stalled input, random in-range data
    run_job(1'b0, 1, 50, -1, 0, 1'b0, 1'b0, 1'b0, 1'b0, -1, 300, 40000);

    // INTT mode, beat 7 out of range, stray cmd_go mid-load
    run_job(1'b1, 1, 30, 7, 3329, 1'b0, 1'b0, 1'b0, 1'b1, -1, 5, 60000);
    chk("lit_wr7_data", wr7_db, 3329);
    repeat (5) @(negedge clk);
    chk("err_range_held", int'(err_range), 1);

    // Timeout: cal_done never rises
    run_job(1'b0, 1, 10, -1, 0, 1'b1, 1'b0, 1'b0, 1'b0, -1, 0, 0);

    // cal_done high on entry, then falls early during drain; wide data range
    run_job(1'b1, 2, 25, -1, 0, 1'b0, 1'b1, 1'b1, 1'b0, -1,
            int'($urandom_range(0, 60000)), int'($urandom_range(0, 60000)));

    // Reset mid-load, then a fresh job from address 0
    run_job(1'b0, 1, 20, -1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 102, 0, 0);
    repeat (2) @(negedge clk);
    run_job(1'b1, 1, 20, -1, 0, 1'b0, 1'b0, 1'b0, 1'b0, -1, 777, 888);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
